// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain initiator: serialises bitstream words LSB first onto
// ccff_head under a gated prog_clk enable, then checks the chain tail.
module ccff_bitstream_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 20,
    parameter int CNT_W        = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] bs_data,
    input  logic                  bs_valid,
    output logic                  bs_ready,
    output logic                  ccff_head,
    input  logic                  ccff_tail,
    output logic                  prog_clk_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int WB_W = $clog2(WORD_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        CHECK,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [WB_W-1:0]       word_bit_q, word_bit_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  first_bit_q, first_bit_d;
    logic                  bs_ready_q, bs_ready_d;
    logic                  ccff_head_q, ccff_head_d;
    logic                  prog_clk_en_q, prog_clk_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        word_bit_d  = word_bit_q;
        bit_cnt_d   = bit_cnt_q;
        first_bit_d = first_bit_q;
        done_d      = done_q;
        error_d     = error_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = FETCH;
                    bit_cnt_d = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                end
            end
            FETCH: begin
                if (bs_valid && bs_ready_q) begin
                    shreg_d    = bs_data;
                    word_bit_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == '0) begin
                    first_bit_d = shreg_q[0];
                end
                shreg_d    = shreg_q >> 1;
                word_bit_d = word_bit_q + WB_W'(1);
                bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                // Chain length wins over word boundary: trailing bits are dropped
                if (bit_cnt_d == CNT_W'(CHAIN_LENGTH)) begin
                    state_d = CHECK;
                end else if (word_bit_d == WB_W'(WORD_WIDTH)) begin
                    state_d = FETCH;
                end
            end
            CHECK: begin
                error_d = (ccff_tail != first_bit_q);
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs registered from the state being entered
        bs_ready_d    = (state_d == FETCH);
        prog_clk_en_d = (state_d == SHIFT);
        ccff_head_d   = prog_clk_en_d & shreg_d[0];
        busy_d        = (state_d == FETCH) || (state_d == SHIFT)
                     || (state_d == CHECK);
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            word_bit_q    <= '0;
            bit_cnt_q     <= '0;
            first_bit_q   <= 1'b0;
            bs_ready_q    <= 1'b0;
            ccff_head_q   <= 1'b0;
            prog_clk_en_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            word_bit_q    <= word_bit_d;
            bit_cnt_q     <= bit_cnt_d;
            first_bit_q   <= first_bit_d;
            bs_ready_q    <= bs_ready_d;
            ccff_head_q   <= ccff_head_d;
            prog_clk_en_q <= prog_clk_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign bs_ready    = bs_ready_q;
    assign ccff_head   = ccff_head_q;
    assign prog_clk_en = prog_clk_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
